apb_reg_slv: RTL and testbench

APB_REG_SLV -- requirements
Module: apb_reg_slv

---
 rtl/apb_reg_slv.sv | 162 ++++++++++++++++
 tb/tb_apb_reg_slv.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_slv.sv
// apb_reg_slv -- APB slave exposing a small register file.
//
// Purpose:
//   NREG read/write registers, a read-only status word and a read-only
//   transaction counter (TCNT), reached through a standard APB setup/access
//   handshake with WAIT programmable wait states per transfer.
//   The register map is word-indexed. Index 0..NREG-1 are the R/W registers,
//   index NREG is STAT_IN, and index NREG+1 is TCNT. All other indices are
//   unmapped.
//
// Ports:
//   APBS_CLK      in   rising-edge clock
//   APBS_RESETN   in   asynchronous active-low reset
//   APBS_PSEL     in   select
//   APBS_PENABLE  in   access phase
//   APBS_PADDR    in   [AW]  byte address
//   APBS_PWDATA   in   [DW]  write data
//   APBS_PWRITE   in   1 = write, 0 = read
//   APBS_PRDATA   out  [DW]  read data (0 unless a clean read completes)
//   APBS_PREADY   out  transfer complete (combinational)
//   APBS_PSLVERR  out  error, qualified by PREADY
//   REG_OUT       out  [NREG*DW]  register i at [i*DW +: DW]
//   WR_PULSE      out  [NREG]  one-cycle strobe after a committed write
//   STAT_IN       in   [DW]  status word, synchronous to APBS_CLK
module apb_reg_slv #(
  parameter int DW   = 16,
  parameter int AW   = 16,
  parameter int NREG = 4,
  parameter int WAIT = 0
) (
  input  logic                 APBS_CLK,
  input  logic                 APBS_RESETN,
  input  logic                 APBS_PSEL,
  input  logic                 APBS_PENABLE,
  input  logic [AW-1:0]        APBS_PADDR,
  input  logic [DW-1:0]        APBS_PWDATA,
  input  logic                 APBS_PWRITE,
  output logic [DW-1:0]        APBS_PRDATA,
  output logic                 APBS_PREADY,
  output logic                 APBS_PSLVERR,
  output logic [NREG*DW-1:0]   REG_OUT,
  output logic [NREG-1:0]      WR_PULSE,
  input  logic [DW-1:0]        STAT_IN
);

  localparam int LSB = $clog2(DW / 8);
  localparam int IW  = AW - LSB;
  localparam logic [IW-1:0] IDX_STAT  = IW'(NREG);
  localparam logic [IW-1:0] IDX_TCNT  = IW'(NREG + 1);
  localparam logic [3:0]    WAIT_LAST = 4'(WAIT);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   regs [NREG];
  logic [DW-1:0]   tcnt;
  logic [3:0]      wait_cnt;
  logic [IW-1:0]   idx_q;
  logic            wr_q;
  logic            err_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;

  logic [IW-1:0]   idx;
  logic            misaligned;
  logic            setup;
  logic            err_dec;
  logic [DW-1:0]   rd_val;

  assign idx = APBS_PADDR[AW-1:LSB];

  // Byte-wide data has no sub-word address bits, so it can never be misaligned.
  generate
    if (LSB == 0) begin : g_byte
      assign misaligned = 1'b0;
    end else begin : g_word
      assign misaligned = |APBS_PADDR[LSB-1:0];
    end
  endgenerate

  assign setup = (state == IDLE) && APBS_PSEL && !APBS_PENABLE;

  // Error is decided from the setup-phase address and held for the whole transfer.
  assign err_dec = misaligned || (idx > IDX_TCNT) ||
                   (APBS_PWRITE && ((idx == IDX_STAT) || (idx == IDX_TCNT)));

  // Read mux, evaluated at the setup phase so TCNT reads return the pre-transfer count.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (idx == IW'(i)) rd_val = regs[i];
    end
    if (idx == IDX_STAT) rd_val = STAT_IN;
    if (idx == IDX_TCNT) rd_val = tcnt;
  end

  assign APBS_PREADY  = (state == ACCESS) && (wait_cnt == WAIT_LAST) &&
                        APBS_PSEL && APBS_PENABLE;
  assign APBS_PSLVERR = APBS_PREADY && err_q;
  assign APBS_PRDATA  = (APBS_PREADY && !err_q) ? rdata_q : '0;

  generate
    for (genvar g = 0; g < NREG; g++) begin : g_regout
      assign REG_OUT[g*DW +: DW] = regs[g];
    end
  endgenerate

  always_ff @(posedge APBS_CLK or negedge APBS_RESETN) begin
    if (!APBS_RESETN) state <= IDLE;
    else              state <= state_nxt;
  end

  // Dropping PSEL mid-access abandons the transfer; completion also returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (setup) state_nxt = ACCESS;
      ACCESS: if (!APBS_PSEL || APBS_PREADY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Setup capture, wait counting, write commit and the transaction counter.
  always_ff @(posedge APBS_CLK or negedge APBS_RESETN) begin
    if (!APBS_RESETN) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      tcnt     <= '0;
      wait_cnt <= '0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      WR_PULSE <= '0;
    end else begin
      WR_PULSE <= '0;
      if (setup) begin
        idx_q    <= idx;
        wr_q     <= APBS_PWRITE;
        err_q    <= err_dec;
        wdata_q  <= APBS_PWDATA;
        rdata_q  <= APBS_PWRITE ? '0 : rd_val;
        wait_cnt <= '0;
      end else if ((state == ACCESS) && APBS_PSEL) begin
        if (APBS_PREADY) begin
          tcnt <= tcnt + 1'b1;
          if (wr_q && !err_q) begin
            for (int i = 0; i < NREG; i++) begin
              if (idx_q == IW'(i)) begin
                regs[i]     <= wdata_q;
                WR_PULSE[i] <= 1'b1;
              end
            end
          end
        end else if (wait_cnt < WAIT_LAST) begin
          wait_cnt <= wait_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_reg_slv.sv
// tb_apb_reg_slv -- self-checking bench for apb_reg_slv.
//
// Purpose:
//   Three 16-bit instances (WAIT = 0, 2, 3) and one 8-bit instance driven by
//   an APB master task. Expected results come from a register-map model
//   (arrays for the registers, a counter for TCNT).
//
// Ports: none (top-level bench).
module tb_apb_reg_slv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   [3];
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [15:0] paddr   [3];
  logic [15:0] pwdata  [3];
  logic [15:0] stat    [3];
  logic [15:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];
  logic [63:0] reg_out [3];
  logic [3:0]  wr_pulse[3];

  logic        rst8, psel8, penable8, pwrite8, pready8, pslverr8;
  logic [15:0] paddr8;
  logic [7:0]  pwdata8, prdata8, stat8;
  logic [31:0] reg_out8;
  logic [3:0]  wr_pulse8;

  int checks = 0;
  int errors = 0;

  logic [15:0] mregs [3][4];
  logic [15:0] mtcnt [3];

  // Instance g uses WAIT = 0, 2, 3 for g = 0, 1, 2.
  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      apb_reg_slv #(.DW(16), .AW(16), .NREG(4), .WAIT((g == 0) ? 0 : g + 1)) u_dut (
        .APBS_CLK    (clk),
        .APBS_RESETN (rst_n[g]),
        .APBS_PSEL   (psel[g]),
        .APBS_PENABLE(penable[g]),
        .APBS_PADDR  (paddr[g]),
        .APBS_PWDATA (pwdata[g]),
        .APBS_PWRITE (pwrite[g]),
        .APBS_PRDATA (prdata[g]),
        .APBS_PREADY (pready[g]),
        .APBS_PSLVERR(pslverr[g]),
        .REG_OUT     (reg_out[g]),
        .WR_PULSE    (wr_pulse[g]),
        .STAT_IN     (stat[g])
      );
    end
  endgenerate

  // 8-bit instance: TCNT wraps after 256 completed transfers.
  apb_reg_slv #(.DW(8), .AW(16), .NREG(4), .WAIT(0)) u_dut8 (
    .APBS_CLK    (clk),
    .APBS_RESETN (rst8),
    .APBS_PSEL   (psel8),
    .APBS_PENABLE(penable8),
    .APBS_PADDR  (paddr8),
    .APBS_PWDATA (pwdata8),
    .APBS_PWRITE (pwrite8),
    .APBS_PRDATA (prdata8),
    .APBS_PREADY (pready8),
    .APBS_PSLVERR(pslverr8),
    .REG_OUT     (reg_out8),
    .WR_PULSE    (wr_pulse8),
    .STAT_IN     (stat8)
  );

  function automatic int waitOf(input int d);
    return (d == 0) ? 0 : d + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One APB transfer on instance d; entered and left at a falling edge so a
  // following call forms a back-to-back setup.
  task automatic applyStimulus(input int d, input logic [15:0] addr, input logic wr,
                               input logic [15:0] wdata, output logic [15:0] rd,
                               output logic err, output int acc, output logic [3:0] pulse);
    psel[d] = 1'b1; penable[d] = 1'b0;
    paddr[d] = addr; pwrite[d] = wr; pwdata[d] = wdata;
    @(negedge clk);
    penable[d] = 1'b1;
    acc = 0;
    while (acc < 20) begin
      #1;
      acc++;
      if (pready[d]) break;
      @(negedge clk);
    end
    rd  = prdata[d];
    err = pslverr[d];
    @(negedge clk);
    pulse = wr_pulse[d];
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic doXfer(input int d, input logic [15:0] addr, input logic wr,
                        input logic [15:0] wdata, input string tag);
    logic [15:0] rd, exp_rd;
    logic        err, exp_err;
    logic [3:0]  pulse, exp_pulse;
    int          acc, idx;
    idx       = int'(addr >> 1);
    exp_err   = addr[0] || (idx > 5) || (wr && (idx >= 4));
    exp_rd    = 16'h0;
    exp_pulse = 4'h0;
    if (!exp_err && !wr) begin
      if (idx < 4)       exp_rd = mregs[d][idx];
      else if (idx == 4) exp_rd = stat[d];
      else               exp_rd = mtcnt[d];
    end
    applyStimulus(d, addr, wr, wdata, rd, err, acc, pulse);
    checkOutput({tag, ".latency"}, 64'(acc), 64'(waitOf(d) + 1));
    checkOutput({tag, ".pslverr"}, 64'(err), 64'(exp_err));
    if (!wr) checkOutput({tag, ".prdata"}, 64'(rd), 64'(exp_rd));
    mtcnt[d] = mtcnt[d] + 16'd1;
    if (wr && !exp_err) begin
      mregs[d][idx] = wdata;
      exp_pulse     = 4'(1 << idx);
    end
    checkOutput({tag, ".wr_pulse"}, 64'(pulse), 64'(exp_pulse));
    checkOutput({tag, ".reg_out"}, reg_out[d],
                {mregs[d][3], mregs[d][2], mregs[d][1], mregs[d][0]});
  endtask

  task automatic xfer8(input logic [15:0] addr, output logic [7:0] rd, output int acc);
    psel8 = 1'b1; penable8 = 1'b0; paddr8 = addr; pwrite8 = 1'b0;
    @(negedge clk);
    penable8 = 1'b1;
    acc = 0;
    while (acc < 20) begin
      #1;
      acc++;
      if (pready8) break;
      @(negedge clk);
    end
    rd = prdata8;
    @(negedge clk);
    psel8 = 1'b0; penable8 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] r16;
    logic [7:0]  r8;
    int          acc;
    logic [15:0] t0;

    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; stat[d] = '0; mtcnt[d] = '0;
      for (int r = 0; r < 4; r++) mregs[d][r] = '0;
    end
    rst8 = 1'b1; psel8 = 1'b0; penable8 = 1'b0; pwrite8 = 1'b0;
    paddr8 = '0; pwdata8 = '0; stat8 = '0;

    // Reset state.
    #1;
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b0;
    rst8 = 1'b0;
    #2;
    for (int d = 0; d < 3; d++) begin
      checkOutput("reset.pready", 64'(pready[d]), 64'(0));
      checkOutput("reset.pslverr", 64'(pslverr[d]), 64'(0));
      checkOutput("reset.prdata", 64'(prdata[d]), 64'(0));
      checkOutput("reset.wr_pulse", 64'(wr_pulse[d]), 64'(0));
      checkOutput("reset.reg_out", reg_out[d], 64'(0));
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    rst8 = 1'b1;

    // Write then read back, WAIT=0.
    doXfer(0, 16'h0002, 1'b1, 16'hA5A5, "r038.wr");
    @(negedge clk);
    checkOutput("r038.pulse_clear", 64'(wr_pulse[0]), 64'(0));
    checkOutput("r038.reg1", 64'(reg_out[0][31:16]), 64'(16'hA5A5));
    doXfer(0, 16'h0002, 1'b0, 16'h0000, "r038.rd");

    // Status read with two wait states.
    stat[1] = 16'h1234;
    doXfer(1, 16'h0008, 1'b0, 16'h0000, "r039");

    // Error cases, each still counted by TCNT.
    t0 = mtcnt[0];
    doXfer(0, 16'h0008, 1'b1, 16'h1111, "r040.wr_stat");
    doXfer(0, 16'h0003, 1'b1, 16'h2222, "r040.wr_misal");
    doXfer(0, 16'h0040, 1'b0, 16'h0000, "r040.rd_unmapped");
    doXfer(0, 16'h000A, 1'b0, 16'h0000, "r040.tcnt");
    checkOutput("r040.tcnt_delta", 64'(mtcnt[0] - t0), 64'(4));

    // Aborted write on WAIT=3 instance.
    doXfer(2, 16'h0004, 1'b1, 16'h5A5A, "r041.pre");
    psel[2] = 1'b1; penable[2] = 1'b0; paddr[2] = 16'h0000; pwrite[2] = 1'b1; pwdata[2] = 16'hDEAD;
    @(negedge clk);
    penable[2] = 1'b1;
    #1 checkOutput("r041.no_ready", 64'(pready[2]), 64'(0));
    @(negedge clk);
    psel[2] = 1'b0; penable[2] = 1'b0;
    #1 checkOutput("r041.no_ready_abort", 64'(pready[2]), 64'(0));
    @(negedge clk);
    checkOutput("r041.no_pulse", 64'(wr_pulse[2]), 64'(0));
    doXfer(2, 16'h000A, 1'b0, 16'h0000, "r041.tcnt");

    // PENABLE without a setup phase is ignored.
    psel[0] = 1'b1; penable[0] = 1'b1; paddr[0] = 16'h0000; pwrite[0] = 1'b1; pwdata[0] = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 checkOutput("r026.no_ready", 64'(pready[0]), 64'(0));
    end
    @(negedge clk);
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge clk);
    doXfer(0, 16'h000A, 1'b0, 16'h0000, "r026.tcnt");

    // Randomized back-to-back traffic on instances 0 and 2.
    for (int i = 0; i < 80; i++) begin
      int          d;
      logic [15:0] a;
      d = (i % 2 == 0) ? 0 : 2;
      a = 16'($urandom_range(0, 13));
      if ($urandom_range(0, 9) == 0) a = 16'h0040;
      stat[d] = 16'($urandom);
      doXfer(d, a, 1'($urandom_range(0, 1)), 16'($urandom), "rand");
    end

    // Reset pulse during the completing cycle of a write, WAIT=2.
    psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = 16'h0000; pwrite[1] = 1'b1; pwdata[1] = 16'hBEEF;
    @(negedge clk);
    penable[1] = 1'b1;
    repeat (2) @(negedge clk);
    #1 checkOutput("r043.ready_before", 64'(pready[1]), 64'(1));
    #1 rst_n[1] = 1'b0;
    #1;
    checkOutput("r043.pready", 64'(pready[1]), 64'(0));
    checkOutput("r043.pslverr", 64'(pslverr[1]), 64'(0));
    checkOutput("r043.prdata", 64'(prdata[1]), 64'(0));
    checkOutput("r043.reg_out", reg_out[1], 64'(0));
    #1 rst_n[1] = 1'b1;
    @(negedge clk);
    psel[1] = 1'b0; penable[1] = 1'b0;
    checkOutput("r043.reg0", reg_out[1], 64'(0));
    checkOutput("r043.wr_pulse", 64'(wr_pulse[1]), 64'(0));
    mtcnt[1] = '0;
    for (int r = 0; r < 4; r++) mregs[1][r] = '0;
    doXfer(1, 16'h0000, 1'b1, 16'h7777, "r043.after_wr");
    doXfer(1, 16'h000A, 1'b0, 16'h0000, "r043.after_tcnt");

    // TCNT wrap on the 8-bit instance (TCNT at byte address 5).
    for (int i = 0; i < 256; i++) begin
      xfer8(16'h0005, r8, acc);
      if (i == 0)   checkOutput("r042.first", 64'(r8), 64'(0));
      if (i == 255) checkOutput("r042.max", 64'(r8), 64'(8'hFF));
    end
    xfer8(16'h0005, r8, acc);
    checkOutput("r042.wrap", 64'(r8), 64'(0));
    checkOutput("r042.latency", 64'(acc), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
